// File: rtl/pipe_hazard_ctrl.sv
// Control and hazard unit for the 5-stage RV32I pipeline (F/D/E/M/W).
// Decodes the D-stage instruction and tracks op/f3/rd/rs for each later
// stage. From these it drives the forwarding selects, the load-use and RAW
// stalls, the branch/jump redirect and the datapath selects. It also
// freezes the whole pipe while the data memory is busy and counts retired
// instructions.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [4:0]        opcode,
    input  logic [2:0]        func3,
    input  logic              func7,
    input  logic [REG_AW-1:0] rd_index,
    input  logic [REG_AW-1:0] rs1_index,
    input  logic [REG_AW-1:0] rs2_index,
    input  logic              alu_result,
    input  logic              m_dm_ready,
    output logic              stall,
    output logic              freeze,
    output logic              next_pc_sel,
    output logic              D_rs1_data_sel,
    output logic              D_rs2_data_sel,
    output logic [1:0]        E_rs1_data_sel,
    output logic [1:0]        E_rs2_data_sel,
    output logic              E_jb_op1_sel,
    output logic              E_alu_op1_sel,
    output logic              E_alu_op2_sel,
    output logic [4:0]        E_op,
    output logic [2:0]        E_f3,
    output logic              E_f7,
    output logic              M_dm_req,
    output logic [3:0]        M_dm_w_en,
    output logic              W_wb_en,
    output logic [REG_AW-1:0] W_rd_index,
    output logic [2:0]        W_f3,
    output logic              W_wb_data_sel,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_ITYPE  = 5'b00100;
    localparam logic [4:0] OP_RTYPE  = 5'b01100;

    // Forwarding select encoding.
    localparam logic [1:0] SEL_W  = 2'd0;
    localparam logic [1:0] SEL_M  = 2'd1;
    localparam logic [1:0] SEL_RF = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [4:0]        op;
        logic [2:0]        f3;
        logic              f7;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } e_stage_t;

    typedef struct packed {
        logic              valid;
        logic [4:0]        op;
        logic [2:0]        f3;
        logic [REG_AW-1:0] rd;
    } mw_stage_t;

    e_stage_t  e_q;
    mw_stage_t m_q, w_q;

    function automatic logic uses_rs1(input logic [4:0] op);
        return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_STORE) ||
               (op == OP_LOAD)  || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [4:0] op);
        return (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    // Opcode class only; the rd != 0 qualifier is applied per stage.
    function automatic logic writes_rd(input logic [4:0] op);
        return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_LOAD) ||
               (op == OP_JAL) || (op == OP_JALR)  || (op == OP_ITYPE) ||
               (op == OP_RTYPE);
    endfunction

    logic d_use1, d_use2;
    logic e_wr, m_wr, w_wr;
    logic e_load, m_load, m_mem;
    logic hazard;

    // Per-stage decode, each term gated by its stage valid bit.
    always_comb begin
        d_use1 = d_valid & uses_rs1(opcode);
        d_use2 = d_valid & uses_rs2(opcode);
        e_wr   = e_q.valid & writes_rd(e_q.op) & (e_q.rd != '0);
        m_wr   = m_q.valid & writes_rd(m_q.op) & (m_q.rd != '0);
        w_wr   = w_q.valid & writes_rd(w_q.op) & (w_q.rd != '0);
        e_load = e_q.valid & (e_q.op == OP_LOAD);
        m_load = m_q.valid & (m_q.op == OP_LOAD);
        m_mem  = m_q.valid & ((m_q.op == OP_LOAD) | (m_q.op == OP_STORE));
    end

    // Freeze, redirect and stall, in priority order freeze > redirect > stall.
    always_comb begin
        logic e_hit, m_hit;
        e_hit = e_wr & ((d_use1 & (e_q.rd == rs1_index)) | (d_use2 & (e_q.rd == rs2_index)));
        m_hit = m_wr & ((d_use1 & (m_q.rd == rs1_index)) | (d_use2 & (m_q.rd == rs2_index)));
        // With forwarding only a load in E must wait. Without it, every
        // in-flight writer must reach W, where the D bypass picks it up.
        hazard      = FWD_EN ? (e_hit & e_load) : (e_hit | m_hit);
        freeze      = m_mem & ~m_dm_ready;
        next_pc_sel = ~freeze & e_q.valid &
                      ((e_q.op == OP_JAL) | (e_q.op == OP_JALR) |
                       ((e_q.op == OP_BRANCH) & alu_result));
        stall       = freeze | (~next_pc_sel & hazard);
    end

    // Forwarding into E from M (non-load) or W, and the D-stage W bypass.
    always_comb begin
        E_rs1_data_sel = SEL_RF;
        E_rs2_data_sel = SEL_RF;
        if (FWD_EN) begin
            if (m_wr & ~m_load & (m_q.rd == e_q.rs1))  E_rs1_data_sel = SEL_M;
            else if (w_wr & (w_q.rd == e_q.rs1))       E_rs1_data_sel = SEL_W;
            if (m_wr & ~m_load & (m_q.rd == e_q.rs2))  E_rs2_data_sel = SEL_M;
            else if (w_wr & (w_q.rd == e_q.rs2))       E_rs2_data_sel = SEL_W;
        end
        W_wb_en        = ~freeze & w_wr;
        D_rs1_data_sel = W_wb_en & d_use1 & (w_q.rd == rs1_index);
        D_rs2_data_sel = W_wb_en & d_use2 & (w_q.rd == rs2_index);
    end

    // Datapath selects and memory-side outputs.
    always_comb begin
        E_op          = e_q.op;
        E_f3          = e_q.f3;
        E_f7          = e_q.f7;
        E_jb_op1_sel  = (e_q.op == OP_JALR);
        E_alu_op1_sel = ~((e_q.op == OP_LUI) | (e_q.op == OP_AUIPC) |
                          (e_q.op == OP_JAL) | (e_q.op == OP_JALR));
        E_alu_op2_sel = (e_q.op == OP_RTYPE) | (e_q.op == OP_BRANCH);
        M_dm_req      = m_mem;
        M_dm_w_en     = 4'b0000;
        if (m_q.valid & (m_q.op == OP_STORE)) begin
            case (m_q.f3)
                3'b000:  M_dm_w_en = 4'b0001;
                3'b001:  M_dm_w_en = 4'b0011;
                3'b010:  M_dm_w_en = 4'b1111;
                default: M_dm_w_en = 4'b0000;
            endcase
        end
        W_rd_index    = w_q.rd;
        W_f3          = w_q.f3;
        W_wb_data_sel = w_q.valid & (w_q.op == OP_LOAD);
    end

    // Stage registers: hold on freeze; otherwise advance, with E taking a
    // bubble on redirect, stall or an empty D slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else if (!freeze) begin
            w_q <= m_q;
            m_q <= '{valid: e_q.valid, op: e_q.op, f3: e_q.f3, rd: e_q.rd};
            if (next_pc_sel | stall | ~d_valid)
                e_q <= '0;
            else
                e_q <= '{valid: 1'b1, op: opcode, f3: func3, f7: func7,
                         rd: rd_index, rs1: rs1_index, rs2: rs2_index};
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retire_cnt <= '0;
        else if (w_q.valid & ~freeze)
            retire_cnt <= retire_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Instance a uses forwarding with a
// 4-bit retire counter. Instance b has forwarding disabled. The stimulus
// queues the expected value of a named output for the current cycle, and a
// monitor compares the queued values on the falling edge.
module tb_pipe_hazard_ctrl;

    localparam logic [4:0] LOAD = 5'b00000, STORE = 5'b01000, JALR = 5'b11001;
    localparam logic [4:0] BR   = 5'b11000, IT    = 5'b00100, RT   = 5'b01100;
    localparam logic [4:0] NOPC = 5'b00011;

    localparam int S_STALL = 0,  S_FREEZE = 1,  S_NPC = 2,   S_E1 = 3,   S_E2 = 4;
    localparam int S_ALU1  = 5,  S_ALU2   = 6,  S_JB  = 7,   S_WBEN = 8, S_WRD = 9;
    localparam int S_WBSEL = 10, S_DMREQ  = 11, S_WEN = 12,  S_CNT = 13, S_EOP = 14;
    localparam int S_D1    = 15, S_D2     = 16;
    localparam int B_STALL = 20, B_NPC = 21, B_E1 = 22, B_E2 = 23, B_D1 = 24;
    localparam int B_D2    = 25, B_EOP = 26, B_JB = 27, B_ALU1 = 28;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    // Instance a signals
    logic a_dv = 0, a_f7 = 0, a_alu = 0, a_rdy = 1;
    logic [4:0] a_op = 0, a_rd = 0, a_rs1 = 0, a_rs2 = 0;
    logic [2:0] a_f3 = 0;
    logic a_stall, a_freeze, a_npc, a_d1, a_d2, a_jb, a_alu1, a_alu2, a_ef7;
    logic a_dmreq, a_wben, a_wbsel;
    logic [1:0] a_e1, a_e2;
    logic [4:0] a_eop, a_wrd;
    logic [2:0] a_ef3, a_wf3;
    logic [3:0] a_wen, a_cnt;

    // Instance b signals
    logic b_dv = 0, b_f7 = 0, b_alu = 0, b_rdy = 1;
    logic [4:0] b_op = 0, b_rd = 0, b_rs1 = 0, b_rs2 = 0;
    logic [2:0] b_f3 = 0;
    logic b_stall, b_freeze, b_npc, b_d1, b_d2, b_jb, b_alu1, b_alu2, b_ef7;
    logic b_dmreq, b_wben, b_wbsel;
    logic [1:0] b_e1, b_e2;
    logic [4:0] b_eop, b_wrd;
    logic [2:0] b_ef3, b_wf3;
    logic [3:0] b_wen;
    logic [31:0] b_cnt;

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .d_valid(a_dv), .opcode(a_op), .func3(a_f3), .func7(a_f7),
        .rd_index(a_rd), .rs1_index(a_rs1), .rs2_index(a_rs2), .alu_result(a_alu),
        .m_dm_ready(a_rdy), .stall(a_stall), .freeze(a_freeze), .next_pc_sel(a_npc),
        .D_rs1_data_sel(a_d1), .D_rs2_data_sel(a_d2), .E_rs1_data_sel(a_e1),
        .E_rs2_data_sel(a_e2), .E_jb_op1_sel(a_jb), .E_alu_op1_sel(a_alu1),
        .E_alu_op2_sel(a_alu2), .E_op(a_eop), .E_f3(a_ef3), .E_f7(a_ef7),
        .M_dm_req(a_dmreq), .M_dm_w_en(a_wen), .W_wb_en(a_wben), .W_rd_index(a_wrd),
        .W_f3(a_wf3), .W_wb_data_sel(a_wbsel), .retire_cnt(a_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .d_valid(b_dv), .opcode(b_op), .func3(b_f3), .func7(b_f7),
        .rd_index(b_rd), .rs1_index(b_rs1), .rs2_index(b_rs2), .alu_result(b_alu),
        .m_dm_ready(b_rdy), .stall(b_stall), .freeze(b_freeze), .next_pc_sel(b_npc),
        .D_rs1_data_sel(b_d1), .D_rs2_data_sel(b_d2), .E_rs1_data_sel(b_e1),
        .E_rs2_data_sel(b_e2), .E_jb_op1_sel(b_jb), .E_alu_op1_sel(b_alu1),
        .E_alu_op2_sel(b_alu2), .E_op(b_eop), .E_f3(b_ef3), .E_f7(b_ef7),
        .M_dm_req(b_dmreq), .M_dm_w_en(b_wen), .W_wb_en(b_wben), .W_rd_index(b_wrd),
        .W_f3(b_wf3), .W_wb_data_sel(b_wbsel), .retire_cnt(b_cnt)
    );

    typedef struct {
        int          stamp;
        int          id;
        logic [31:0] exp;
        string       nm;
    } item_t;

    item_t q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get(input int id);
        case (id)
            S_STALL: return 32'(a_stall);
            S_FREEZE: return 32'(a_freeze);
            S_NPC:   return 32'(a_npc);
            S_E1:    return 32'(a_e1);
            S_E2:    return 32'(a_e2);
            S_ALU1:  return 32'(a_alu1);
            S_ALU2:  return 32'(a_alu2);
            S_JB:    return 32'(a_jb);
            S_WBEN:  return 32'(a_wben);
            S_WRD:   return 32'(a_wrd);
            S_WBSEL: return 32'(a_wbsel);
            S_DMREQ: return 32'(a_dmreq);
            S_WEN:   return 32'(a_wen);
            S_CNT:   return 32'(a_cnt);
            S_EOP:   return 32'(a_eop);
            S_D1:    return 32'(a_d1);
            S_D2:    return 32'(a_d2);
            B_STALL: return 32'(b_stall);
            B_NPC:   return 32'(b_npc);
            B_E1:    return 32'(b_e1);
            B_E2:    return 32'(b_e2);
            B_D1:    return 32'(b_d1);
            B_D2:    return 32'(b_d2);
            B_EOP:   return 32'(b_eop);
            B_JB:    return 32'(b_jb);
            B_ALU1:  return 32'(b_alu1);
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Compare every expectation queued for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].stamp <= cyc) begin
            item_t it;
            logic [31:0] act;
            it  = q.pop_front();
            act = get(it.id);
            checks = checks + 1;
            if (act !== it.exp) begin
                errors = errors + 1;
                $display("FAIL %s (cycle %0d): got %0d, expected %0d", it.nm, it.stamp, act, it.exp);
            end
        end
    end

    initial begin
        #20000;
        errors = errors + 1;
        $display("FAIL timeout: stimulus did not finish (cycle %0d)", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic chk(input int id, input logic [31:0] e, input string nm);
        q.push_back('{cyc, id, e, nm});
    endtask

    task automatic chk_now(input int id, input logic [31:0] e, input string nm);
        logic [31:0] act;
        act = get(id);
        checks = checks + 1;
        if (act !== e) begin
            errors = errors + 1;
            $display("FAIL %s (now, cycle %0d): got %0d, expected %0d", nm, cyc, act, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_ins(input logic [4:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        a_dv = 1; a_op = op; a_f3 = f3; a_rd = rd; a_rs1 = rs1; a_rs2 = rs2;
    endtask

    task automatic a_nop();
        a_dv = 0; a_op = 0; a_f3 = 0; a_rd = 0; a_rs1 = 0; a_rs2 = 0;
    endtask

    task automatic b_ins(input logic [4:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        b_dv = 1; b_op = op; b_f3 = f3; b_rd = rd; b_rs1 = rs1; b_rs2 = rs2;
    endtask

    task automatic b_nop();
        b_dv = 0; b_op = 0; b_f3 = 0; b_rd = 0; b_rs1 = 0; b_rs2 = 0;
    endtask

    initial begin
        #1 rst = 1;
        tick();
        // Reset state
        chk(S_STALL, 0, "rst_stall");   chk(S_FREEZE, 0, "rst_freeze");
        chk(S_NPC, 0, "rst_npc");       chk(S_E1, 2, "rst_e1");
        chk(S_E2, 2, "rst_e2");         chk(S_D1, 0, "rst_d1");
        chk(S_D2, 0, "rst_d2");         chk(S_ALU1, 1, "rst_alu1");
        chk(S_ALU2, 0, "rst_alu2");     chk(S_JB, 0, "rst_jb");
        chk(S_WBEN, 0, "rst_wben");     chk(S_DMREQ, 0, "rst_dmreq");
        chk(S_WEN, 0, "rst_wen");       chk(S_CNT, 0, "rst_cnt");
        chk(S_WBSEL, 0, "rst_wbsel");   chk(B_STALL, 0, "rst_b_stall");
        tick();
        rst = 0;

        // lw x5 ; add x6,x5,x7
        a_ins(LOAD, 3'b010, 5, 1, 0);   chk(S_STALL, 0, "lw_issue_stall");
        tick();
        a_ins(RT, 3'b000, 6, 5, 7);     chk(S_STALL, 1, "lu_stall");
        tick();
        chk(S_STALL, 0, "lu_stall_release"); chk(S_DMREQ, 1, "lw_dmreq"); chk(S_WEN, 0, "lw_wen");
        tick();
        a_nop();
        chk(S_E1, 0, "lu_e1_from_w"); chk(S_E2, 2, "lu_e2_rf");
        chk(S_WBEN, 1, "lw_wben");    chk(S_WRD, 5, "lw_wrd");
        chk(S_WBSEL, 1, "lw_wbsel");  chk(S_ALU2, 1, "add_alu2");
        tick();
        chk(S_CNT, 1, "cnt_after_lw");
        tick();
        chk(S_WBEN, 1, "add_wben"); chk(S_WBSEL, 0, "add_wbsel");
        tick();
        chk(S_CNT, 2, "cnt_after_add");

        // add x1 ; add x2,x1,x1 with forwarding
        a_ins(RT, 0, 1, 2, 3);
        tick();
        a_ins(RT, 0, 2, 1, 1);          chk(S_STALL, 0, "fwd_no_stall");
        tick();
        a_nop();
        chk(S_E1, 1, "fwd_e1_from_m"); chk(S_E2, 1, "fwd_e2_from_m");
        tick(); tick(); tick();
        chk(S_CNT, 4, "cnt_after_fwd");

        // beq taken; the following addi is killed
        a_ins(BR, 0, 0, 1, 2);
        tick();
        a_ins(IT, 0, 9, 0, 0); a_alu = 1;
        chk(S_NPC, 1, "beq_npc"); chk(S_STALL, 0, "beq_stall");
        chk(S_ALU2, 1, "beq_alu2"); chk(S_JB, 0, "beq_jb");
        tick();
        a_nop(); a_alu = 0;
        chk(S_NPC, 0, "beq_npc_drop"); chk(S_EOP, 0, "beq_e_bubble");
        tick(); tick(); tick();
        chk(S_CNT, 5, "cnt_kill_not_counted");

        // addi x7 ; sh with the data memory busy for 3 cycles
        a_ins(IT, 0, 7, 0, 0);
        tick();
        a_ins(STORE, 3'b001, 0, 6, 5);
        tick();
        a_nop();
        tick();
        a_rdy = 0;
        chk(S_FREEZE, 1, "frz1"); chk(S_STALL, 1, "frz1_stall"); chk(S_NPC, 0, "frz1_npc");
        chk(S_WBEN, 0, "frz1_wben"); chk(S_WEN, 3, "frz1_wen"); chk(S_DMREQ, 1, "frz1_dmreq");
        tick();
        chk(S_FREEZE, 1, "frz2"); chk(S_WEN, 3, "frz2_wen");
        tick();
        chk(S_FREEZE, 1, "frz3"); chk(S_CNT, 5, "frz3_cnt"); chk(S_WBEN, 0, "frz3_wben");
        tick();
        a_rdy = 1;
        chk(S_FREEZE, 0, "frz_release"); chk(S_STALL, 0, "frz_release_stall");
        chk(S_WBEN, 1, "frz_release_wben"); chk(S_WRD, 7, "frz_release_wrd");
        chk(S_WEN, 3, "frz_release_wen");
        tick();
        chk(S_CNT, 6, "cnt_after_frz"); chk(S_WBEN, 0, "sh_wben"); chk(S_WEN, 0, "wen_clear");
        tick();
        chk(S_CNT, 7, "cnt_after_sh");

        // addi x0,x0,1 ; add x3,x0,x0
        a_ins(IT, 0, 0, 0, 0);          chk(S_STALL, 0, "x0_stall0");
        tick();
        a_ins(RT, 0, 3, 0, 0);          chk(S_STALL, 0, "x0_stall1");
        tick();
        a_nop();
        chk(S_E1, 2, "x0_e1"); chk(S_E2, 2, "x0_e2");
        tick();
        chk(S_WBEN, 0, "x0_wben");
        tick();
        chk(S_WBEN, 1, "x3_wben"); chk(S_WRD, 3, "x3_wrd");
        tick();
        chk(S_CNT, 9, "cnt_before_wrap");

        // Eight valid NOP-class instructions take the 4-bit counter to 17 mod 16
        for (int k = 0; k < 8; k++) begin
            a_ins(NOPC, 0, 10, 0, 0);
            if (k == 3) chk(S_WBEN, 0, "nop_no_wb");
            tick();
        end
        a_nop();
        tick(); tick();
        chk(S_CNT, 0, "cnt_wrap_16");
        tick();
        chk(S_CNT, 1, "cnt_wrap_17");

        // Instance b: no forwarding
        b_ins(RT, 0, 1, 2, 3);          chk(B_STALL, 0, "b_issue");
        tick();
        b_ins(RT, 0, 2, 1, 1);          chk(B_STALL, 1, "b_raw_stall_e");
        tick();
        chk(B_STALL, 1, "b_raw_stall_m"); chk(B_D1, 0, "b_d1_early");
        tick();
        chk(B_STALL, 0, "b_raw_release"); chk(B_D1, 1, "b_d1_bypass"); chk(B_D2, 1, "b_d2_bypass");
        tick();
        b_nop();
        chk(B_E1, 2, "b_e1_rf"); chk(B_E2, 2, "b_e2_rf");
        tick();
        b_ins(IT, 0, 4, 0, 0);
        tick();
        b_ins(BR, 0, 0, 0, 0);          chk(B_STALL, 0, "b_beq_issue");
        tick();
        b_ins(RT, 0, 5, 4, 0); b_alu = 1;
        chk(B_NPC, 1, "b_beq_npc"); chk(B_STALL, 0, "b_stall_suppressed");
        tick();
        b_nop(); b_alu = 0;
        chk(B_EOP, 0, "b_e_bubble"); chk(B_NPC, 0, "b_npc_drop");
        tick();
        b_ins(JALR, 0, 1, 2, 0);
        tick();
        b_nop();
        chk(B_NPC, 1, "b_jalr_npc"); chk(B_JB, 1, "b_jalr_jb"); chk(B_ALU1, 0, "b_jalr_alu1");
        tick();

        // Reset asserted while instance a is frozen on a load
        a_ins(LOAD, 3'b010, 8, 1, 0);
        tick();
        a_nop();
        tick();
        a_rdy = 0;
        chk(S_FREEZE, 1, "pre_rst_freeze"); chk(S_DMREQ, 1, "pre_rst_dmreq");
        tick();
        rst = 1;
        #1;
        chk_now(S_FREEZE, 0, "arst_freeze"); chk_now(S_STALL, 0, "arst_stall");
        chk_now(S_DMREQ, 0, "arst_dmreq");   chk_now(S_CNT, 0, "arst_cnt");
        chk_now(S_E1, 2, "arst_e1");         chk_now(S_ALU1, 1, "arst_alu1");
        tick();
        a_rdy = 1;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
